bcd_run_ctrl: RTL and testbench

Run controller for the team's BCD up/down digit counters. It sequences a cascade of mod-10 digits from a loaded start value to a target value in a chosen direction, at a programmable step rate. It provides a start/done handshake and supports pause and abort. It sits between the front-panel/control logic and the digit datapath, and is the only agent that steps the digits.

---
 rtl/bcd_run_pkg.sv | 19 +
 rtl/bcd_run_digit.sv | 40 ++++
 rtl/bcd_run_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_bcd_run_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_run_pkg.sv
// Shared types and helpers for the BCD run controller and its digit cells.
// Holds the run-state enum, BCD digit limits and a digit validity check.
package bcd_run_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic digit_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_run_digit.sv
// One mod-10 up/down digit cell, chained by cout -> cin into a cascade.
// Ports: clk, reset (sync, high), load/load_val (parallel load, wins over
// stepping), en/cin (step when both high), dir (1 = up), q (digit value),
// cout (carry when counting up, borrow when counting down; combinational).
module bcd_digit
    import bcd_run_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       dir,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    logic step;

    assign step = en & cin;

    // The next digit steps only when this one rolls over.
    assign cout = step & (dir ? (q == BCD_MAX) : (q == BCD_MIN));

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            if (dir) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_run_ctrl.sv
// Run controller: steps an NDIG-digit BCD cascade from start_val to
// target_val at one step per tick_div+1 cycles, with pause and abort.
// Ports: clk, reset (sync, high); start/abort/pause controls; dir, start_val,
// target_val, tick_div run settings (latched at accepted start); q (count),
// busy (RUN/PAUSE), done (1-cycle arrival pulse), wrap (1-cycle roll-over
// pulse), err (sticky, start rejected for a non-BCD digit).
// Build option: define BCD_AUTO_RELOAD_EN to restart from start_val after
// every arrival instead of finishing; runs then end only on abort.
module bcd_run_ctrl
    import bcd_run_pkg::*;
#(
    parameter int NDIG       = 2,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  dir,
    input  logic [4*NDIG-1:0]     start_val,
    input  logic [4*NDIG-1:0]     target_val,
    input  logic [PRESCALE_W-1:0] tick_div,
    output logic [4*NDIG-1:0]     q,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap,
    output logic                  err
);

    localparam int W = 4 * NDIG;

`ifdef BCD_AUTO_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    // One BCD step of a whole NDIG-digit value, up or down.
    function automatic logic [W-1:0] bcd_step(
        input logic [W-1:0] v,
        input logic         up
    );
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    c = (d == BCD_MAX);
                    d = c ? BCD_MIN : d + 4'd1;
                end else begin
                    c = (d == BCD_MIN);
                    d = c ? BCD_MAX : d - 4'd1;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            ok = ok & digit_ok(v[4*i +: 4]);
        end
        return ok;
    endfunction

    state_t                state;
    state_t                state_n;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] presc_n;
    logic [PRESCALE_W-1:0] div_lat;
    logic [W-1:0]          tgt_lat;
    logic [W-1:0]          sv_lat;
    logic                  dir_lat;

    logic                  start_ok;
    logic                  accept;
    logic                  reject;
    logic                  tick;
    logic                  run_en;
    logic                  done_n;
    logic                  at_tgt;
    logic                  arrive;
    logic                  reload_step;
    logic [W-1:0]          pre_tgt;
    logic [W-1:0]          load_val;
    logic                  load;
    logic [NDIG:0]         carry;

    assign start_ok = all_bcd(start_val) & all_bcd(target_val);

    // The value one step before the target: when a step leaves q here,
    // the stepped q is the target.
    assign pre_tgt = bcd_step(tgt_lat, ~dir_lat);
    assign at_tgt  = (q == tgt_lat);
    assign arrive  = (q == pre_tgt) & ~(RELOAD & at_tgt);

    assign reload_step = RELOAD & tick & at_tgt;

    always_comb begin
        state_n = state;
        presc_n = presc;
        accept  = 1'b0;
        reject  = 1'b0;
        tick    = 1'b0;
        run_en  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (start_ok) begin
                        accept  = 1'b1;
                        presc_n = '0;
                        if (start_val == target_val) begin
                            done_n  = 1'b1;
                            state_n = RELOAD ? RUN : DONE;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN, PAUSE: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (pause) begin
                    state_n = PAUSE;
                end else begin
                    state_n = RUN;
                    run_en  = 1'b1;
                    if (presc == div_lat) begin
                        presc_n = '0;
                        tick    = 1'b1;
                        if (arrive) begin
                            done_n  = 1'b1;
                            state_n = RELOAD ? RUN : DONE;
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            div_lat <= '0;
            tgt_lat <= '0;
            sv_lat  <= '0;
            dir_lat <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            if (accept) begin
                div_lat <= tick_div;
                tgt_lat <= target_val;
                sv_lat  <= start_val;
                dir_lat <= dir;
            end
            busy <= (state_n == RUN) || (state_n == PAUSE);
            done <= done_n;
            // A reload never rolls over: the digits are loaded, not stepped.
            wrap <= carry[NDIG];
            if (reject) begin
                err <= 1'b1;
            end else if (accept) begin
                err <= 1'b0;
            end
        end
    end

    assign load     = accept | reload_step;
    assign load_val = accept ? start_val : sv_lat;
    assign carry[0] = tick;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit u_dig (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .load_val (load_val[4*i +: 4]),
            .en       (run_en & ~reload_step),
            .dir      (dir_lat),
            .cin      (carry[i]),
            .q        (q[4*i +: 4]),
            .cout     (carry[i+1])
        );
    end

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// Scoreboard bench for bcd_run_ctrl (NDIG=2): directed and random runs,
// with done/wrap events predicted from step counts and checked by a monitor.
module tb_bcd_run_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic       dir;
    logic [7:0] start_val;
    logic [7:0] target_val;
    logic [7:0] tick_div;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    typedef struct {
        int qv;
        int cyc;
    } exp_t;

    exp_t done_q[$];
    exp_t wrap_q[$];

    int cyc    = 0;
    int passes = 0;
    int total  = 0;

    bcd_run_ctrl #(
        .NDIG       (2),
        .PRESCALE_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .dir        (dir),
        .start_val  (start_val),
        .target_val (target_val),
        .tick_div   (tick_div),
        .q          (q),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    // Monitor: every done/wrap pulse must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end else begin
                e = done_q.pop_front();
                chk("done_q", int'(q), e.qv);
                chk("done_cycle", cyc, e.cyc);
                chk("done_busy", int'(busy), 0);
            end
        end
        if (wrap) begin
            if (wrap_q.size() == 0) begin
                chk("unexpected_wrap", int'(wrap), 0);
            end else begin
                e = wrap_q.pop_front();
                chk("wrap_q", int'(q), e.qv);
                chk("wrap_cycle", cyc, e.cyc);
            end
        end
    end

    // One complete run. Reference: N steps = distance s->t in dir mod 100;
    // each step costs dv+1 cycles, each paused cycle adds one.
    // k/L: pause high on edges ta+k .. ta+k+L-1 (L=0: no pause).
    // scr: after start, scramble settings and re-request start (ignored).
    task automatic run(input int s, input int t, input bit d,
                       input int dv, input int k, input int l,
                       input bit scr);
        int   n;
        int   m;
        int   ta;
        int   jw;
        int   g;
        exp_t e;
        n  = d ? (t - s + 100) % 100 : (s - t + 100) % 100;
        m  = n * (dv + 1);
        @(negedge clk);
        start_val  = to_bcd(s);
        target_val = to_bcd(t);
        dir        = d;
        tick_div   = 8'(dv);
        start      = 1'b1;
        ta = cyc + 1;
        e = '{qv: int'(to_bcd(t)), cyc: ta + m + l};
        done_q.push_back(e);
        jw = (d ? 100 - s : s + 1);
        if (jw <= n) begin
            jw = jw * (dv + 1);
            e = '{qv: (d ? 0 : 'h99),
                  cyc: ta + jw + ((l > 0 && k <= jw) ? l : 0)};
            wrap_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", int'(err), 0);
        chk("busy_at_start", int'(busy), (m > 0) ? 1 : 0);
        if (scr && l == 0) begin
            start_val  = 8'($urandom_range(99, 0) % 10);
            target_val = 8'($urandom_range(9, 0));
            dir        = 1'($urandom);
            tick_div   = 8'($urandom);
            start      = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (l > 0) begin
            while (cyc < ta + k - 1) @(negedge clk);
            pause = 1'b1;
            repeat (l) @(negedge clk);
            pause = 1'b0;
        end
        g = 0;
        while (done_q.size() != 0 && g < m + l + 50) begin
            @(negedge clk);
            g++;
        end
        if (done_q.size() != 0) begin
            chk("done_timeout", done_q.size(), 0);
            done_q.delete();
        end
        chk("wrap_count", wrap_q.size(), 0);
        wrap_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int   g;
        int   s;
        int   t;
        int   dv;
        int   n;
        int   m;
        int   k;
        int   l;
        bit   d;
        logic [7:0] qprev;

        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pause      = 1'b0;
        dir        = 1'b0;
        start_val  = '0;
        target_val = '0;
        tick_div   = '0;
        repeat (2) @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_err", int'(err), 0);
        reset = 1'b0;

`ifdef BCD_AUTO_RELOAD_EN
        begin
            int   ta;
            exp_t e;
            logic [7:0] seq [3];
            seq[0] = 8'h05;
            seq[1] = 8'h06;
            seq[2] = 8'h07;
            @(negedge clk);
            start_val  = 8'h05;
            target_val = 8'h07;
            dir        = 1'b1;
            tick_div   = 8'd0;
            start      = 1'b1;
            ta = cyc + 1;
            e = '{qv: 'h07, cyc: ta + 2};
            done_q.push_back(e);
            e = '{qv: 'h07, cyc: ta + 5};
            done_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 7; i++) begin
                chk("reload_q", int'(q), int'(seq[i % 3]));
                chk("reload_busy", int'(busy), 1);
                if (i == 6) abort = 1'b1;
                @(negedge clk);
            end
            abort = 1'b0;
            chk("reload_abort_busy", int'(busy), 0);
            chk("reload_done_left", done_q.size(), 0);
            done_q.delete();
        end
`else
        run(7, 12, 1'b1, 0, 0, 0, 1'b0);
        run(1, 98, 1'b0, 2, 0, 0, 1'b0);
        run(0, 50, 1'b1, 1, 7, 4, 1'b0);
        run(33, 33, 1'b1, 3, 0, 0, 1'b0);

        // Non-BCD start digit is refused.
        @(negedge clk);
        qprev      = q;
        start_val  = 8'h1A;
        target_val = 8'h05;
        dir        = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_err", int'(err), 1);
        chk("bad_busy", int'(busy), 0);
        chk("bad_q", int'(q), int'(qprev));
        run(95, 3, 1'b1, 1, 0, 0, 1'b1);

        // Abort at q = 20 leaves q there, no done.
        @(negedge clk);
        start_val  = 8'h00;
        target_val = 8'h50;
        dir        = 1'b1;
        tick_div   = 8'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (q != 8'h20 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("abort_reach", int'(q), 'h20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(q), 'h20);
        repeat (4) @(negedge clk);
        chk("abort_q_hold", int'(q), 'h20);

        // Reset mid-run at q = 42.
        start_val  = 8'h00;
        target_val = 8'h90;
        dir        = 1'b1;
        tick_div   = 8'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (q != 8'h42 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rst_reach", int'(q), 'h42);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;

        for (int r = 0; r < 20; r++) begin
            s  = $urandom_range(99, 0);
            t  = $urandom_range(99, 0);
            d  = 1'($urandom);
            dv = $urandom_range(3, 0);
            n  = d ? (t - s + 100) % 100 : (s - t + 100) % 100;
            m  = n * (dv + 1);
            k  = 0;
            l  = 0;
            if (m >= 2 && $urandom_range(1, 0) == 1) begin
                k = $urandom_range(m - 1, 1);
                l = $urandom_range(3, 1);
            end
            run(s, t, d, dv, k, l, 1'($urandom));
        end
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
